// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Responds on the CPU data-memory bus inside a 16-byte window at BASE_ADDR.
// The CPU pushes bytes into a small TX FIFO and a baud-rate FSM serialises
// them LSB first.
// rd_data is zero outside the window, so it can be OR-ed with the RAM read data.
//
// Bus handshake: there is no valid/ready pair. A store is accepted
// unconditionally on the rising edge where wr_sig is high and the address
// decodes to this block. A TXDATA store that finds the FIFO full is dropped
// and recorded in the sticky overflow flag. Reads are purely combinational
// from addr.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_sig,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       sel;
  logic [1:0] off;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_divisor;

  assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
  assign off        = addr[3:2];
  assign wr_txdata  = wr_sig && sel && (off == OFF_TXDATA);
  assign wr_status  = wr_sig && sel && (off == OFF_STATUS);
  assign wr_divisor = wr_sig && sel && (off == OFF_DIVISOR);

  // Byte lanes inside a word and the upper store bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wr_data[31:16]};

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [15:0] divisor;
  logic        overflow;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          pop;
  logic [7:0]    head;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  // Fullness is judged before the edge, so a pop on the same edge cannot
  // rescue a store that arrives while the FIFO is full.
  assign push  = wr_txdata && !full;
  assign drop  = wr_txdata && full;
  assign head  = fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Transmit FSM and datapath
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;
  logic [7:0]  shift;
  logic [15:0] bit_len;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic        baud_done;
  logic        last_bit;
  logic        busy;

  assign baud_done = (baud_cnt == (bit_len - 16'd1));
  assign last_bit  = (bit_idx == 3'd7);

  // Divisor register: a zero divisor would stall the baud counter, so store 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor <= DIV_RESET;
    end else if (wr_divisor) begin
      divisor <= (wr_data[15:0] == 16'd0) ? 16'd1 : wr_data[15:0];
    end
  end

  // Sticky overflow flag: set by a dropped store, cleared by writing 1 to bit 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (wr_status && wr_data[3]) begin
      overflow <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_data[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic: each non-idle state lasts exactly bit_len cycles,
  // DATA repeats eight times, and STOP chains straight into START when a byte is waiting.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_done && last_bit) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_next = empty ? IDLE : START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: line level, busy flag and the FIFO pop that starts a frame.
  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    pop  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        pop  = !empty;
      end
      START: begin
        tx = 1'b0;
      end
      DATA: begin
        tx = shift[0];
      end
      STOP: begin
        pop = baud_done && !empty;
      end
      default: begin
        tx   = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  // Frame datapath: a pop loads the byte and snapshots the divisor, so divisor
  // writes during a frame only take effect from the next frame onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift    <= 8'h00;
      bit_len  <= DIV_RESET;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else if (pop) begin
      shift    <= head;
      bit_len  <= divisor;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else if (state != IDLE) begin
      if (baud_done) begin
        baud_cnt <= 16'd0;
        if (state == DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  // Interrupt derived purely from registered state.
  assign irq_empty = empty && (state == IDLE);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [3:0] count_field;
  assign count_field = 4'(count);

  // Combinational register read; zero outside the window so it can be OR-ed.
  always_comb begin
    rd_data = 32'd0;
    if (sel) begin
      case (off)
        OFF_STATUS:  rd_data = {24'd0, count_field, overflow, empty, full, busy};
        OFF_DIVISOR: rd_data = {16'd0, divisor};
        default:     rd_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx.
// The expected line waveform comes from a frame model: each queued
// {bit_len, byte} produces start(0), eight data bits LSB first, and stop(1),
// with each bit lasting bit_len cycles. Frames follow one another back to back.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_DIV = BASE + 32'd8;
  localparam logic [31:0] A_R3  = BASE + 32'd12;
  localparam logic [31:0] A_OFF = 32'h0000_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = A_OFF;
  logic        wr_sig = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        tx;
  logic        irq_empty;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wr_sig    (wr_sig),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  // Posedge counter and a per-cycle log of tx, sampled on the falling edge.
  int   cyc = 0;
  logic tx_hist [0:65535];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 65536) tx_hist[cyc] <= tx;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [23:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Store; edge_idx is the posedge index on which the store is taken.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int edge_idx);
    @(negedge clk);
    addr     = a;
    wr_data  = d;
    wr_sig   = 1'b1;
    edge_idx = cyc + 1;
    @(posedge clk);
    #1;
    wr_sig  = 1'b0;
    addr    = A_OFF;
    wr_data = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr   = a;
    wr_sig = 1'b0;
    #1;
    d = rd_data;
  endtask

  // Return once tx_hist holds every cycle up to and including target.
  task automatic wait_past(input int target);
    while (cyc <= target) @(negedge clk);
    #1;
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int len, input int c);
    int pos;
    pos = c / len;
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Check every queued frame starting at cycle 'start', then the idle level after them.
  task automatic check_frames(input int start, output int next);
    logic [23:0] item;
    int          len;
    int          errs;
    int          s;
    s = start;
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      len  = int'(item[23:8]);
      wait_past(s + 10 * len - 1);
      errs = 0;
      for (int c = 0; c < 10 * len; c++) begin
        if (tx_hist[s + c] !== exp_tx(item[7:0], len, c)) errs++;
      end
      n_cmp++;
      if (errs != 0) begin
        n_err++;
        $display("FAIL frame byte=%02h div=%0d start=%0d: %0d wrong tx cycles, required 0",
                 item[7:0], len, s, errs);
      end
      s = s + 10 * len;
    end
    wait_past(s);
    n_cmp++;
    if (tx_hist[s] !== 1'b1) begin
      n_err++;
      $display("FAIL idle_after_frames: tx=%b at cycle %0d, required 1", tx_hist[s], s);
    end
    next = s;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_0004) begin
      n_err++; $display("FAIL reset_status: got %h, required %h", d, 32'h4);
    end
    bus_read(A_DIV, d);
    n_cmp++;
    if (d !== 32'd434) begin
      n_err++; $display("FAIL reset_divisor: got %0d, required 434", d);
    end
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL reset_tx: got %b, required 1", tx);
    end
    n_cmp++;
    if (irq_empty !== 1'b1) begin
      n_err++; $display("FAIL reset_irq: got %b, required 1", irq_empty);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] d;
    int          p;
    int          e;
    int          s;
    logic [15:0] len;
    logic [7:0]  b;
    bus_write(A_DIV, 32'd4, e);
    bus_read(A_DIV, d);
    n_cmp++;
    if (d !== 32'd4) begin
      n_err++; $display("FAIL divisor_rw: got %0d, required 4", d);
    end
    bus_write(A_TX, 32'h0000_00A5, p);
    exp_q.push_back({16'd4, 8'hA5});
    wait_past(p + 15);
    bus_read(A_ST, d);
    n_cmp++;
    if (d[0] !== 1'b1) begin
      n_err++; $display("FAIL busy_mid_frame: got %b, required 1", d[0]);
    end
    n_cmp++;
    if (irq_empty !== 1'b0) begin
      n_err++; $display("FAIL irq_mid_frame: got %b, required 0", irq_empty);
    end
    wait_past(p + 37);
    bus_read(A_ST, d);
    n_cmp++;
    if (d[0] !== 1'b1) begin
      n_err++; $display("FAIL busy_in_stop: got %b, required 1", d[0]);
    end
    check_frames(p + 1, s);
    n_cmp++;
    if (irq_empty !== 1'b1) begin
      n_err++; $display("FAIL irq_after_single: got %b, required 1", irq_empty);
    end
    for (int i = 0; i < 3; i++) begin
      len = 16'($urandom_range(1, 6));
      b   = 8'($urandom_range(0, 255));
      bus_write(A_DIV, {16'd0, len}, e);
      bus_write(A_TX, {24'd0, b}, p);
      exp_q.push_back({len, b});
      check_frames(p + 1, s);
      n_cmp++;
      if (irq_empty !== 1'b1) begin
        n_err++; $display("FAIL irq_after_random_%0d: got %b, required 1", i, irq_empty);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          p;
    int          e;
    int          s;
    int          n;
    logic [15:0] len;
    logic [7:0]  b;
    bus_write(A_DIV, 32'd2, e);
    bus_write(A_TX, 32'h01, p);
    bus_write(A_TX, 32'h02, e);
    bus_write(A_TX, 32'h03, e);
    exp_q.push_back({16'd2, 8'h01});
    exp_q.push_back({16'd2, 8'h02});
    exp_q.push_back({16'd2, 8'h03});
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_0021) begin
      n_err++; $display("FAIL b2b_status: got %h, required %h", d, 32'h21);
    end
    check_frames(p + 1, s);
    n_cmp++;
    if (irq_empty !== 1'b1) begin
      n_err++; $display("FAIL irq_after_b2b: got %b, required 1", irq_empty);
    end
    len = 16'($urandom_range(1, 3));
    n   = $urandom_range(2, 4);
    bus_write(A_DIV, {16'd0, len}, e);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(A_TX, {24'd0, b}, e);
      if (i == 0) p = e;
      exp_q.push_back({len, b});
    end
    check_frames(p + 1, s);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int          p;
    int          e;
    int          s;
    logic [7:0]  b;
    bus_write(A_DIV, 32'd16, e);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(A_TX, {24'd0, b}, e);
      if (i == 0) p = e;
      if (i < 5) exp_q.push_back({16'd16, b});
    end
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_004B) begin
      n_err++; $display("FAIL overflow_status: got %h, required %h", d, 32'h4B);
    end
    bus_write(A_ST, 32'd0, e);
    bus_read(A_ST, d);
    n_cmp++;
    if (d[3] !== 1'b1) begin
      n_err++; $display("FAIL overflow_write0: got %b, required 1", d[3]);
    end
    bus_write(A_ST, 32'd8, e);
    bus_read(A_ST, d);
    n_cmp++;
    if (d[3] !== 1'b0) begin
      n_err++; $display("FAIL overflow_clear: got %b, required 0", d[3]);
    end
    check_frames(p + 1, s);
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_0004) begin
      n_err++; $display("FAIL status_after_overflow: got %h, required %h", d, 32'h4);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    int          p;
    int          e;
    int          s;
    int          ones;
    logic [7:0]  b1;
    logic [7:0]  b2;
    bus_write(BASE + 32'h10, 32'h5A, e);
    bus_read(BASE + 32'h14, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++; $display("FAIL unselected_read: got %h, required 0", d);
    end
    bus_read(BASE + 32'h10, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++; $display("FAIL unselected_read_base: got %h, required 0", d);
    end
    wait_past(e + 10);
    ones = 0;
    for (int c = e; c <= e + 10; c++) if (tx_hist[c] === 1'b1) ones++;
    n_cmp++;
    if (ones != 11) begin
      n_err++; $display("FAIL unselected_no_frame: %0d idle cycles, required 11", ones);
    end
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_0004) begin
      n_err++; $display("FAIL unselected_no_push: got %h, required %h", d, 32'h4);
    end
    bus_read(A_R3, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++; $display("FAIL off3_read: got %h, required 0", d);
    end
    bus_read(A_TX, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++; $display("FAIL txdata_read: got %h, required 0", d);
    end
    bus_write(A_DIV, 32'd9, e);
    bus_write(A_R3, 32'hFFFF_FFFF, e);
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_0004) begin
      n_err++; $display("FAIL off3_write_status: got %h, required %h", d, 32'h4);
    end
    bus_read(A_DIV, d);
    n_cmp++;
    if (d !== 32'd9) begin
      n_err++; $display("FAIL off3_write_divisor: got %0d, required 9", d);
    end
    bus_write(A_DIV, 32'd0, e);
    bus_read(A_DIV, d);
    n_cmp++;
    if (d !== 32'd1) begin
      n_err++; $display("FAIL divisor_zero: got %0d, required 1", d);
    end
    bus_write(A_DIV, 32'hABCD_0007, e);
    bus_read(BASE + 32'h9, d);
    n_cmp++;
    if (d !== 32'd7) begin
      n_err++; $display("FAIL divisor_upper_bits: got %h, required 7", d);
    end
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    bus_write(A_DIV, 32'd3, e);
    bus_write(A_TX, {24'd0, b1}, p);
    bus_write(A_DIV, 32'd5, e);
    bus_write(A_TX, {24'd0, b2}, e);
    exp_q.push_back({16'd3, b1});
    exp_q.push_back({16'd5, b2});
    check_frames(p + 1, s);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int          p;
    int          e;
    int          r;
    int          ones;
    bus_write(A_DIV, 32'd4, e);
    bus_write(A_TX, 32'h00, p);
    bus_write(A_TX, 32'hAA, e);
    bus_write(A_TX, 32'h55, e);
    while (cyc < p + 8) @(negedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++; $display("FAIL mid_frame_data_low: got %b, required 0", tx);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_tx: got %b, required 1", tx);
    end
    n_cmp++;
    if (irq_empty !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_irq: got %b, required 1", irq_empty);
    end
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_0004) begin
      n_err++; $display("FAIL reset_mid_status: got %h, required %h", d, 32'h4);
    end
    @(negedge clk);
    reset = 1'b0;
    r = cyc;
    wait_past(r + 60);
    ones = 0;
    for (int c = r; c <= r + 60; c++) if (tx_hist[c] === 1'b1) ones++;
    n_cmp++;
    if (ones != 61) begin
      n_err++; $display("FAIL reset_mid_no_resume: %0d idle cycles, required 61", ones);
    end
    bus_read(A_ST, d);
    n_cmp++;
    if (d !== 32'h0000_0004) begin
      n_err++; $display("FAIL reset_mid_status_after: got %h, required %h", d, 32'h4);
    end
    bus_read(A_DIV, d);
    n_cmp++;
    if (d !== 32'd434) begin
      n_err++; $display("FAIL reset_mid_divisor: got %0d, required 434", d);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_decode();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus (addr / wr_sig / wr_data / rd_data), in parallel with the data RAM.
- The CPU stores bytes into a small TX FIFO; a baud-rate FSM serialises them as 8N1 frames on tx.
- rd_data is zero when the block is not selected, so it can be OR-ed with the RAM read data at top level.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the 16-byte register window; BASE_ADDR[3:0] must be 0.
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, minimum 2.
- DIV_RESET, 16'd434, reset value of the divisor register (clock cycles per bit).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  CPU data bus byte address.
- wr_sig  in  1  CPU store strobe; a write takes effect on the clk edge while high.
- wr_data  in  32  CPU store data.
- rd_data  out  32  combinational read data; 0 when the block is not selected.
- tx  out  1  serial output; idle high.
- irq_empty  out  1  high while the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset (asynchronous):
  - tx=1, FSM=IDLE, FIFO empty (count=0), divisor=DIV_RESET, overflow=0, irq_empty=1.
  - Reset asserted mid-frame aborts the frame immediately; tx returns to 1 and queued bytes are lost.
- Decode:
  - sel = (addr[31:4] == BASE_ADDR[31:4]); off = addr[3:2]; addr[1:0] is ignored.
- Register map:
  - off 0 TXDATA. Write pushes wr_data[7:0]. Reads 0.
  - off 1 STATUS, read-only except bit3:
    - bit0 busy (FSM != IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[7:4] FIFO count
    - other bits 0
    - Writing 1 to bit3 clears overflow; writing 0 leaves it unchanged.
  - off 2 DIVISOR: R/W on bits[15:0], upper bits read 0. Writing 0 stores 1.
  - off 3: reads 0, writes ignored.
- Read mux: rd_data is combinational from addr; 0 whenever sel=0 (wr_sig irrelevant).
- FIFO:
  - Push on an edge with wr_sig & sel & off==0.
  - If full before the edge, the byte is dropped and overflow is set, even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full: count unchanged, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop the head into an 8-bit shift register, latch the divisor into bit_len, clear the bit counter, go to START. tx goes low on the edge after the push is registered (push at edge N -> tx=0 after edge N+1).
  - START: tx=0 for bit_len cycles, then go to DATA.
  - DATA: tx=shift[0]; after bit_len cycles shift right and increment bit index. After bit 7 completes, go to STOP. Order is LSB first.
  - STOP: tx=1 for bit_len cycles. Then if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter: counts 0..bit_len-1 and wraps at bit boundaries.
- Divisor writes mid-frame affect the next frame only; a frame is exactly 10*bit_len cycles.
- irq_empty is registered-state-derived: (count==0) && (FSM==IDLE).

Test Plan:
- Reset:
  - Assert reset.
  - Read STATUS -> 32'h0000_0004 (empty).
  - Read DIVISOR -> 434.
  - tx=1, irq_empty=1.
- Single byte:
  - Write DIVISOR=4, then TXDATA=8'hA5.
  - tx low one cycle after the push, for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles.
  - busy=1 throughout; irq_empty=1 after 40 cycles.
- Back-to-back:
  - DIVISOR=2; push 8'h01, 8'h02, 8'h03 on consecutive cycles.
  - Three frames with no idle gap, 60 cycles total.
  - STATUS count reads 2 right after the third push (one byte already popped).
- Overflow:
  - DIVISOR=16; push 6 bytes while the first frame is active.
  - Count saturates at 4 and STATUS bit3=1; exactly 5 bytes are transmitted.
  - Writing STATUS=8 clears bit3.
- Decode and divisor edge cases:
  - Write to BASE_ADDR+0x10 -> no push; rd_data=0 for that address; read of off 3 -> 0.
  - Write DIVISOR=0 -> reads 1.
  - Changing DIVISOR mid-frame leaves the current frame at its original 10*bit_len length.
- Reset mid-frame:
  - Assert reset during DATA with 2 bytes queued.
  - tx=1 immediately, STATUS=4, and no further frame is sent after release.
